// File: rtl/store_narrow_pkg.sv
// rtl/store_narrow_pkg.sv - shared types and helpers for the store narrowing path
package store_narrow_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [3:0] size_bytes(input size_t size);
        return 4'd1 << size;
    endfunction

    // Keeps only the bytes the store actually writes so padding beats carry zeros.
    function automatic logic [63:0] narrow_mask(input size_t size);
        case (size)
            SZ_BYTE: return 64'h0000_0000_0000_00FF;
            SZ_HALF: return 64'h0000_0000_0000_FFFF;
            SZ_WORD: return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/store_beat_shifter.sv
// rtl/store_beat_shifter.sv - loadable right-shift register emitting one beat per advance
module store_beat_shifter #(
    parameter int BEAT_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    advance,
    input  logic [63:0]             load_data,
    input  logic [3:0]              load_beats,
    output logic [8*BEAT_BYTES-1:0] beat_data,
    output logic                    last
);

    logic [63:0] shreg;
    logic [3:0]  cnt;
    logic [3:0]  beats_m1;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            cnt      <= '0;
            beats_m1 <= '0;
        end else if (load) begin
            shreg    <= load_data;
            cnt      <= '0;
            beats_m1 <= load_beats - 4'd1;
        end else if (advance) begin
            shreg    <= shreg >> (8 * BEAT_BYTES);
            cnt      <= cnt + 4'd1;
        end
    end

    assign beat_data = shreg[8*BEAT_BYTES-1:0];
    assign last      = (cnt == beats_m1);

endmodule

// File: rtl/store_narrower.sv
// rtl/store_narrower.sv - narrows a 64-bit store to its size and serializes it into memory beats
module store_narrower
    import store_narrow_pkg::*;
#(
    parameter int BEAT_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [63:0]             req_addr,
    input  logic [63:0]             req_data,
    input  logic [1:0]              req_size,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [63:0]             mem_addr,
    output logic [8*BEAT_BYTES-1:0] mem_wdata,
    output logic [BEAT_BYTES-1:0]   mem_be,
    output logic                    mem_last,
    output logic                    done
);

    generate
        if (!(BEAT_BYTES == 1 || BEAT_BYTES == 2 || BEAT_BYTES == 4 || BEAT_BYTES == 8)) begin : g_bad_beat
            $error("store_narrower: BEAT_BYTES must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    state_t                  state;
    logic                    accept;
    logic                    advance;
    logic                    shifter_last;
    logic [3:0]              nbytes;
    logic [3:0]              beats_calc;
    logic [8:0]              be_ones;
    logic [BEAT_BYTES-1:0]   be_calc;
    logic [63:0]             narrowed;

    always_comb begin
        nbytes   = size_bytes(size_t'(req_size));
        narrowed = req_data & narrow_mask(size_t'(req_size));
        be_ones  = (9'd1 << nbytes) - 9'd1;
        if ({1'b0, req_size} >= 3'(BEAT_SHIFT))
            beats_calc = 4'd1 << (req_size - 2'(BEAT_SHIFT));
        else
            beats_calc = 4'd1;
        // Sub-beat stores only enable their own bytes; everything else fills whole beats.
        if ({1'b0, nbytes} < 5'(BEAT_BYTES))
            be_calc = be_ones[BEAT_BYTES-1:0];
        else
            be_calc = '1;
    end

    assign req_ready = (state == IDLE);
    assign mem_valid = (state == SEND);
    assign mem_last  = (state == SEND) && shifter_last;
    assign accept    = (state == IDLE) && req_valid;
    assign advance   = (state == SEND) && mem_ready && !shifter_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            done     <= 1'b0;
            mem_addr <= '0;
            mem_be   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state    <= SEND;
                        mem_addr <= req_addr;
                        mem_be   <= be_calc;
                    end
                end
                SEND: begin
                    if (mem_ready) begin
                        if (shifter_last) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            mem_addr <= mem_addr + 64'(BEAT_BYTES);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    store_beat_shifter #(
        .BEAT_BYTES(BEAT_BYTES)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .advance   (advance),
        .load_data (narrowed),
        .load_beats(beats_calc),
        .beat_data (mem_wdata),
        .last      (shifter_last)
    );

endmodule

// File: tb/tb_store_narrower.sv
// tb/tb_store_narrower.sv - directed self-checking bench for store_narrower (1- and 4-byte beats)
module tb_store_narrower;

    logic        clk;
    logic        reset;

    logic        a_req_valid, a_req_ready, a_mem_valid, a_mem_ready, a_mem_last, a_done;
    logic [63:0] a_req_addr, a_req_data, a_mem_addr;
    logic [1:0]  a_req_size;
    logic [7:0]  a_mem_wdata;
    logic [0:0]  a_mem_be;

    logic        b_req_valid, b_req_ready, b_mem_valid, b_mem_ready, b_mem_last, b_done;
    logic [63:0] b_req_addr, b_req_data, b_mem_addr;
    logic [1:0]  b_req_size;
    logic [31:0] b_mem_wdata;
    logic [3:0]  b_mem_be;

    int checks = 0;
    int errors = 0;

    store_narrower #(.BEAT_BYTES(1)) u_dut_b1 (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .req_data(a_req_data), .req_size(a_req_size),
        .mem_valid(a_mem_valid), .mem_ready(a_mem_ready), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_be(a_mem_be), .mem_last(a_mem_last), .done(a_done)
    );

    store_narrower #(.BEAT_BYTES(4)) u_dut_b4 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .req_data(b_req_data), .req_size(b_req_size),
        .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .mem_last(b_mem_last), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_a(input logic [63:0] addr, input logic [63:0] data, input logic [1:0] size);
        a_req_addr  = addr;
        a_req_data  = data;
        a_req_size  = size;
        a_req_valid = 1'b1;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
    endtask

    task automatic send_b(input logic [63:0] addr, input logic [63:0] data, input logic [1:0] size);
        b_req_addr  = addr;
        b_req_data  = data;
        b_req_size  = size;
        b_req_valid = 1'b1;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_req_valid = 0; a_req_addr = 0; a_req_data = 0; a_req_size = 0; a_mem_ready = 1;
        b_req_valid = 0; b_req_addr = 0; b_req_data = 0; b_req_size = 0; b_mem_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // reset state
        check("rst_valid", a_mem_valid, 0);
        check("rst_ready", a_req_ready, 1);
        check("rst_done",  a_done, 0);
        check("rst_addr",  a_mem_addr, 0);
        check("rst_wdata", a_mem_wdata, 0);
        check("rst_be",    a_mem_be, 0);
        check("rst_last",  a_mem_last, 0);
        check("rst_b_be",  b_mem_be, 0);

        // single byte store
        send_a(64'h100, 64'h1122_3344_5566_77AB, 2'b00);
        @(negedge clk);
        check("t1_valid", a_mem_valid, 1);
        check("t1_addr",  a_mem_addr, 64'h100);
        check("t1_wdata", a_mem_wdata, 8'hAB);
        check("t1_be",    a_mem_be, 1);
        check("t1_last",  a_mem_last, 1);
        check("t1_done0", a_done, 0);
        check("t1_ready0", a_req_ready, 0);
        @(negedge clk);
        check("t1_done",  a_done, 1);
        check("t1_ready", a_req_ready, 1);
        check("t1_idle",  a_mem_valid, 0);
        @(negedge clk);
        check("t1_done_pulse", a_done, 0);

        // dword as eight byte beats
        send_a(64'h200, 64'h0807_0605_0403_0201, 2'b11);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t2_valid", a_mem_valid, 1);
            check("t2_addr",  a_mem_addr, 64'h200 + 64'(k));
            check("t2_wdata", a_mem_wdata, 64'(k + 1));
            check("t2_last",  a_mem_last, (k == 7) ? 1 : 0);
            check("t2_done0", a_done, 0);
        end
        @(negedge clk);
        check("t2_done", a_done, 1);

        // half store with backpressure on the first beat
        @(negedge clk);
        a_mem_ready = 1'b0;
        send_a(64'h300, 64'h0000_0000_0000_BEEF, 2'b01);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_hold_addr",  a_mem_addr, 64'h300);
            check("t3_hold_wdata", a_mem_wdata, 8'hEF);
            check("t3_hold_last",  a_mem_last, 0);
            check("t3_hold_valid", a_mem_valid, 1);
            if (i == 3) a_mem_ready = 1'b1;
        end
        @(negedge clk);
        check("t3_addr1",  a_mem_addr, 64'h301);
        check("t3_wdata1", a_mem_wdata, 8'hBE);
        check("t3_last1",  a_mem_last, 1);
        @(negedge clk);
        check("t3_done", a_done, 1);

        // 4-byte beats: byte store is zero padded
        send_b(64'h400, 64'hFFFF_FFFF_FFFF_FF5A, 2'b00);
        @(negedge clk);
        check("t4_addr",  b_mem_addr, 64'h400);
        check("t4_wdata", b_mem_wdata, 32'h0000_005A);
        check("t4_be",    b_mem_be, 4'b0001);
        check("t4_last",  b_mem_last, 1);
        @(negedge clk);
        check("t4_done", b_done, 1);

        // 4-byte beats: half store
        send_b(64'h410, 64'h1234_5678_9ABC_BEEF, 2'b01);
        @(negedge clk);
        check("t4h_wdata", b_mem_wdata, 32'h0000_BEEF);
        check("t4h_be",    b_mem_be, 4'b0011);
        check("t4h_last",  b_mem_last, 1);
        @(negedge clk);

        // 4-byte beats: dword in two beats
        send_b(64'h420, 64'h8877_6655_4433_2211, 2'b11);
        @(negedge clk);
        check("t4d_addr0",  b_mem_addr, 64'h420);
        check("t4d_wdata0", b_mem_wdata, 32'h4433_2211);
        check("t4d_be0",    b_mem_be, 4'hF);
        check("t4d_last0",  b_mem_last, 0);
        @(negedge clk);
        check("t4d_addr1",  b_mem_addr, 64'h424);
        check("t4d_wdata1", b_mem_wdata, 32'h8877_6655);
        check("t4d_last1",  b_mem_last, 1);
        @(negedge clk);
        check("t4d_done", b_done, 1);

        // address wrap, with a second request held valid throughout
        @(negedge clk);
        a_req_addr  = 64'hFFFF_FFFF_FFFF_FFFE;
        a_req_data  = 64'hDEAD_BEEF_4433_2211;
        a_req_size  = 2'b10;
        a_req_valid = 1'b1;
        @(posedge clk);
        #1;
        a_req_addr = 64'h500;
        a_req_data = 64'h0000_0000_0000_0077;
        a_req_size = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_addr",  a_mem_addr, 64'hFFFF_FFFF_FFFF_FFFE + 64'(k));
            check("t5_wdata", a_mem_wdata, 64'((k + 1) * 8'h11));
            check("t5_ready", a_req_ready, 0);
        end
        @(negedge clk);
        check("t5_done",       a_done, 1);
        check("t5_ready_done", a_req_ready, 1);
        check("t5_idle",       a_mem_valid, 0);
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        @(negedge clk);
        check("t5_second_valid", a_mem_valid, 1);
        check("t5_second_addr",  a_mem_addr, 64'h500);
        check("t5_second_wdata", a_mem_wdata, 8'h77);
        check("t5_second_last",  a_mem_last, 1);
        @(negedge clk);
        check("t5_second_done", a_done, 1);

        // reset mid-transfer abandons the store
        @(negedge clk);
        send_a(64'h600, 64'h0807_0605_0403_0201, 2'b11);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6_addr", a_mem_addr, 64'h600 + 64'(k));
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_valid", a_mem_valid, 0);
        check("t6_ready", a_req_ready, 1);
        check("t6_done",  a_done, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_no_beat", a_mem_valid, 0);
            check("t6_no_done", a_done, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_narrower.md
Name: store_narrower

Overview:
- Store-side counterpart of the load-path zero extender. It takes one 64-bit store request (STURB/STURH/STURW/STUR) from the MEM stage and narrows it to the store size.
- It serializes the narrowed data into little-endian beats of BEAT_BYTES bytes for a narrow data-memory write port.
- It uses a valid/ready handshake on both sides and pulses done after the final beat, so the pipeline stall logic can release MEM.

Parameters:
- BEAT_BYTES, 1, bytes per memory beat. Legal values are 1, 2, 4, 8; any other value is a compile-time error.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  store request present
- req_ready  output  1  block can accept a request
- req_addr  input  64  byte address of the store
- req_data  input  64  register data; only the low (1<<req_size) bytes are used
- req_size  input  2  00 byte, 01 half, 10 word, 11 dword
- mem_valid  output  1  beat present on mem_*
- mem_ready  input  1  memory accepts the beat
- mem_addr  output  64  byte address of the current beat
- mem_wdata  output  8*BEAT_BYTES  beat data
- mem_be  output  BEAT_BYTES  byte enables for the beat
- mem_last  output  1  current beat is the final beat of the store
- done  output  1  one-cycle pulse in the cycle after the final beat handshake

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - reset is synchronous and active-high.
  - Reset values: state IDLE, mem_valid 0, mem_last 0, done 0, mem_addr 0, mem_wdata 0, mem_be 0, beat counter 0.
  - Reset asserted mid-transfer abandons the store. No further beats are issued and no done pulse is produced.
- Store size and beat count:
  - nbytes = 1 << req_size.
  - Number of beats = max(1, nbytes / BEAT_BYTES).
  - If nbytes < BEAT_BYTES: a single beat. mem_be has its low nbytes bits set. Unused upper bytes of mem_wdata are 0 (zero-padded, never stale data).
  - Otherwise every beat has mem_be all ones.
- Beat ordering:
  - Beats go out lowest byte first (little-endian).
  - Beat k carries bytes [k*BEAT_BYTES +: BEAT_BYTES] of the narrowed data.
  - Beat k has mem_addr = req_addr + k*BEAT_BYTES. This is a 64-bit modular add, so the address wraps past all-ones to 0.
  - No alignment check; addresses pass through unchanged.
- FSM, two states:
  - IDLE: req_ready = 1, mem_valid = 0. When req_valid is high, capture addr, narrowed data, size and beat count, then go to SEND.
  - SEND: req_ready = 0, mem_valid = 1. mem_last = 1 when the beat counter equals beats-1.
    - On mem_valid && mem_ready && !mem_last: advance to the next beat (shift data, increment address, increment counter).
    - On mem_valid && mem_ready && mem_last: go to IDLE, and done = 1 in the following cycle.
- Timing:
  - The first beat is valid in the cycle after acceptance.
  - With mem_ready held high, one beat completes per cycle.
  - done is asserted N+1 cycles after the acceptance edge, where N is the beat count.
  - There is one idle cycle minimum between stores (req_ready is low in SEND and high again in IDLE).
- Backpressure: while mem_valid && !mem_ready, mem_addr, mem_wdata, mem_be and mem_last hold stable.
- Request changes: changes to req_* during SEND are ignored.
- done timing: done is a registered pulse. It coincides with req_ready returning to 1, and a new request may be accepted in that same cycle.

Decomposition:
- Shared package store_narrow_pkg:
  - enum size_t: SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_DWORD = 2'b11.
  - Function size_bytes(size_t), returning the store size in bytes.
  - FSM state enum {IDLE, SEND}.
- One sub-module, store_beat_shifter: a loadable 64-bit right-shift register that drops BEAT_BYTES bytes per advance, with its beat counter. It exposes the current beat data and a last flag.
- The top level holds the FSM, the address incrementer and the byte-enable generation.

Test Plan:
- BEAT_BYTES=1, size 00, data 0x1122_3344_5566_77AB, addr 0x100, mem_ready=1 -> one beat: addr 0x100, wdata 0xAB, be 1, last 1. done high exactly 2 cycles after acceptance.
- BEAT_BYTES=1, size 11, data 0x0807_0605_0403_0201, addr 0x200 -> wdata 01..08 on addr 0x200..0x207 in consecutive cycles, last only on the 8th beat, done 9 cycles after acceptance.
- BEAT_BYTES=1, size 01, data 0xBEEF, mem_ready low for 3 cycles on the first beat -> addr and wdata 0xEF held stable for 4 cycles, then 0xBE with last=1, then done.
- BEAT_BYTES=4, size 00, data 0xFFFF_FFFF_FFFF_FF5A -> single beat: wdata 0x0000_005A, be 4'b0001, last 1.
- BEAT_BYTES=1, size 10, addr 0xFFFF_FFFF_FFFF_FFFE -> beat addrs ...FFFE, ...FFFF, 0x0, 0x1. A second request held valid throughout the transfer is accepted only in the done cycle.
- BEAT_BYTES=1, size 11, reset asserted after 3 beats -> next cycle mem_valid 0, req_ready 1, done 0, with no further beats.
